rv_fetch: RTL and testbench
===========================

# rv_fetch

Instruction-fetch stage that generates the byte address for the synchronous instruction memory and pairs each returned 32-bit word with its PC. It presents the pair to decode through a valid/ready handshake. It also absorbs decode back-pressure and redirects from execute (branch/jump) without losing or duplicating instructions. It sits directly upstream of the instruction memory (drives its address) and directly downstream of it (consumes its read data).

## Interface
- `PC_WIDTH`, 10: byte-address width; matches the instruction-memory address port.
- `RESET_PC`, 10'h000: first fetch address after reset; must be 4-byte aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `redirect_i` in 1: execute requests PC change this cycle.
- `redirect_pc_i` in PC_WIDTH: redirect target byte address.
- `id_ready_i` in 1: decode accepts the current `if_*` pair this cycle.
- `imem_addr_o` out PC_WIDTH: combinational address to the instruction memory; memory uses bits [PC_WIDTH-1:2].
- `imem_data_i` in 32: memory read data; valid one cycle after the address was presented.
- `if_valid_o` out 1: `if_pc_o`/`if_instr_o` hold a live instruction.
- `if_pc_o` out PC_WIDTH: PC of the presented instruction.
- `if_instr_o` out 32: presented instruction; equals `imem_data_i`.
- `misalign_o` out 1: redirect target misaligned (see Configuration).

## Operation
- State:
  - `pc_q`: PC whose data is currently on `imem_data_i`.
  - `valid_q`: a read for `pc_q` has been issued.
  - `mis_q`: sticky misalign flag.
- Address select, in priority order:
  1. `redirect_i` → `redirect_pc_i` (low bits per Configuration).
  2. `!valid_q` → `pc_q`.
  3. `if_valid_o && !id_ready_i` (stall) → `pc_q`, a re-read of the same word.
  4. Otherwise → `pc_q + 4`.
- Every edge: `pc_q <= imem_addr_o`.
- `valid_q <= 1` on every edge after reset release.
- Increment is modulo 2^PC_WIDTH: `pc_q = 10'h3FC` advances to `10'h000` with no flag.
- `if_valid_o = valid_q && !redirect_i && !mis_q`. A redirect kills the in-flight wrong-path instruction in the same cycle.
- Handshake: a transfer occurs when `if_valid_o && id_ready_i`. Once asserted, `if_valid_o`/`if_pc_o`/`if_instr_o` stay stable until the transfer or a redirect.
- Redirect together with `id_ready_i=0`: redirect wins, and the stalled instruction is discarded.

## Timing
- Reset values: `pc_q=RESET_PC`, `valid_q=0`, `mis_q=0`. Outputs during reset: `imem_addr_o=RESET_PC`, `if_valid_o=0`, `if_pc_o=RESET_PC`, `misalign_o=0`.
- First edge after `rst_n` rises issues the read of `RESET_PC`. `if_valid_o=1` in the following cycle.
- Address-to-data latency is 1 cycle. Sustained throughput is 1 instruction/cycle while `id_ready_i=1`.
- Redirect penalty: the redirect-cycle output is killed, and the target instruction is valid in the next cycle (one bubble).
- Stall: zero additional latency on release. The instruction after a stalled one appears the cycle after the transfer.
- If `rst_n` is asserted mid-stream, all state clears immediately and asynchronously. No partial instruction is presented.

## Configuration
- `RV_FETCH_MISALIGN_EN` defined:
  - A redirect with `redirect_pc_i[1:0]!=0` sets `mis_q`.
  - `misalign_o=1` from the next cycle, and `if_valid_o` is forced to 0.
  - The address is still issued with `[1:0]` cleared.
  - `mis_q` clears only on reset or a later aligned redirect.
- Undefined: `redirect_pc_i[1:0]` is silently forced to 0, `misalign_o` is tied 0, and `mis_q` is absent.

## Test plan
- Reset release, memory preloaded with word i = i, `id_ready_i=1` → first valid cycle shows `if_pc_o=0x000`, `if_instr_o=0`, then PCs 0x004, 0x008, … on consecutive cycles.
- Hold `id_ready_i=0` for 3 cycles at PC 0x010 → `if_pc_o=0x010` and `if_instr_o` stay stable for 4 cycles, then 0x014 follows with no gap or duplicate.
- `redirect_i=1`, `redirect_pc_i=0x100`, while 0x020 is presented → `if_valid_o=0` that cycle, next cycle `if_pc_o=0x100` with `if_instr_o=mem[64]`.
- Redirect while stalled → redirect wins, and the stalled instruction is never transferred.
- Run from 0x3F8 → observe 0x3F8, 0x3FC, then 0x000.
- With `RV_FETCH_MISALIGN_EN`, redirect to 0x102 → `misalign_o=1` and `if_valid_o=0` until a redirect to 0x200 restores normal fetch. Without the macro, the same redirect fetches 0x100.

Source files
------------

// File: rtl/rv_fetch.sv
// rv_fetch: instruction-fetch stage.
// Drives the synchronous instruction-memory address, pairs the returned word
// with its PC and hands the pair to decode over a valid/ready handshake.
// Absorbs decode back-pressure by re-reading the same word, and applies
// execute redirects with a single bubble.
// Optional feature macro: RV_FETCH_MISALIGN_EN (sticky misaligned-redirect flag).
module rv_fetch #(
    parameter int unsigned          PC_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                id_ready_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]         imem_data_i,
    output logic                if_valid_o,
    output logic [PC_WIDTH-1:0] if_pc_o,
    output logic [31:0]         if_instr_o,
    output logic                misalign_o
);

    // pc_q is the address whose data is on imem_data_i this cycle.
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    // valid_q says a read for pc_q has actually been issued.
    logic                valid_q;
    logic                mis_w;
    logic                stall;
    logic [PC_WIDTH-1:0] redirect_tgt;

    // Memory is word-addressed, so the target always goes out word-aligned.
    assign redirect_tgt = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};

`ifdef RV_FETCH_MISALIGN_EN
    logic mis_q;

    // Sticky misalign flag: each redirect re-evaluates it, otherwise it holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mis_q <= 1'b0;
        else if (redirect_i)
            mis_q <= |redirect_pc_i[1:0];
    end

    assign mis_w = mis_q;
`else
    // Low target bits are deliberately ignored in this build.
    logic unused_redirect_lo;
    assign unused_redirect_lo = ^redirect_pc_i[1:0];
    assign mis_w = 1'b0;
`endif

    // A redirect kills whatever is being presented in the same cycle.
    assign if_valid_o = valid_q && !redirect_i && !mis_w;
    assign if_pc_o    = pc_q;
    assign if_instr_o = imem_data_i;
    assign misalign_o = mis_w;

    // Decode is holding off a live instruction: re-read the same word so
    // imem_data_i stays stable next cycle.
    assign stall = if_valid_o && !id_ready_i;

    // Next fetch address, highest priority first; increment wraps silently.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(4);
        if (redirect_i)
            pc_d = redirect_tgt;
        else if (!valid_q)
            pc_d = pc_q;
        else if (stall)
            pc_d = pc_q;
    end

    assign imem_addr_o = pc_d;

    // PC follows the issued address every cycle; valid rises after the first read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv_fetch.sv
// tb_rv_fetch: self-checking bench for rv_fetch with a synchronous memory
// model and an instruction-stream reference model (expected next PC).
module tb_rv_fetch;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          redirect_i = 1'b0;
    logic [PW-1:0] redirect_pc_i = '0;
    logic          id_ready_i = 1'b0;
    logic [PW-1:0] imem_addr_o;
    logic [31:0]   imem_data_i;
    logic          if_valid_o;
    logic [PW-1:0] if_pc_o;
    logic [31:0]   if_instr_o;
    logic          misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    rv_fetch #(.PC_WIDTH(PW), .RESET_PC(10'h000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .imem_addr_o   (imem_addr_o),
        .imem_data_i   (imem_data_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .misalign_o    (misalign_o)
    );

    // Synchronous instruction memory: one-cycle read latency.
    always @(posedge clk) imem_data_i <= mem[imem_addr_o[PW-1:2]];

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    endtask

    // Drive one cycle of inputs; outputs are observed 1 time unit later.
    task automatic cyc(input logic rd, input logic [PW-1:0] rpc, input logic rdy);
        @(negedge clk);
        redirect_i    = rd;
        redirect_pc_i = rpc;
        id_ready_i    = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        id_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Stream with ready=1 until target PC is presented (bounded).
    task automatic run_to(input logic [PW-1:0] tgt, output bit ok);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(1'b0, '0, 1'b0);
            if (if_valid_o && if_pc_o == tgt) begin ok = 1; break; end
            id_ready_i = 1'b1;
            #1;
        end
    endtask

    task automatic test_reset();
        fill_linear();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if_valid_o !== 1'b0 || imem_addr_o !== 10'h000 || if_pc_o !== 10'h000 || misalign_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b addr=%h pc=%h mis=%b, want 0/000/000/0",
                     if_valid_o, imem_addr_o, if_pc_o, misalign_o);
        end
        do_reset();
        repeat (5) cyc(1'b0, '0, 1'b1);
        // Asynchronous reset mid-stream clears state immediately.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if_valid_o !== 1'b0 || if_pc_o !== 10'h000 || imem_addr_o !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b pc=%h addr=%h, want 0/000/000",
                     if_valid_o, if_pc_o, imem_addr_o);
        end
    endtask

    task automatic test_stream();
        fill_linear();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, '0, 1'b1);
            n_checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 10'(4*k) || if_instr_o !== 32'(k)) begin
                n_fail++;
                $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         k, if_valid_o, if_pc_o, if_instr_o, 10'(4*k), 32'(k));
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        fill_linear();
        do_reset();
        run_to(10'h010, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL stall_reach: pc 010 not seen, got pc=%h", if_pc_o); end
        // run_to left ready low on the cycle that reached 0x010: that is stall cycle 1.
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc(1'b0, '0, 1'b0);
            n_checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 10'h010 || if_instr_o !== 32'd4) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h, want 1/010/4",
                         k, if_valid_o, if_pc_o, if_instr_o);
            end
        end
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 10'h010 || if_instr_o !== 32'd4) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b pc=%h instr=%h, want 1/010/4",
                     if_valid_o, if_pc_o, if_instr_o);
        end
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 10'h014 || if_instr_o !== 32'd5) begin
            n_fail++;
            $display("FAIL stall_next: valid=%b pc=%h instr=%h, want 1/014/5",
                     if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_redirect();
        bit ok;
        fill_linear();
        do_reset();
        run_to(10'h020, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL redir_reach: pc 020 not seen, got pc=%h", if_pc_o); end
        redirect_i = 1'b1; redirect_pc_i = 10'h100; id_ready_i = 1'b1;
        #1;
        n_checks++;
        if (if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL redir_kill: valid=%b, want 0", if_valid_o);
        end
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 10'h100 || if_instr_o !== 32'd64) begin
            n_fail++;
            $display("FAIL redir_target: valid=%b pc=%h instr=%h, want 1/100/40",
                     if_valid_o, if_pc_o, if_instr_o);
        end
    endtask

    task automatic test_redirect_stall();
        bit ok;
        fill_linear();
        do_reset();
        run_to(10'h010, ok);   // presented 0x010, ready=0
        cyc(1'b1, 10'h080, 1'b0);
        n_checks++;
        if (if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rstall_kill: valid=%b, want 0", if_valid_o);
        end
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 10'h080 || if_instr_o !== 32'd32) begin
            n_fail++;
            $display("FAIL rstall_target: valid=%b pc=%h instr=%h, want 1/080/20",
                     if_valid_o, if_pc_o, if_instr_o);
        end
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 10'h084) begin
            n_fail++; $display("FAIL rstall_next: valid=%b pc=%h, want 1/084", if_valid_o, if_pc_o);
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] want [3];
        want[0] = 10'h3F8; want[1] = 10'h3FC; want[2] = 10'h000;
        fill_linear();
        do_reset();
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 10'h3F8, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            n_checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== want[k] || if_instr_o !== 32'(want[k] >> 2)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h",
                         k, if_valid_o, if_pc_o, if_instr_o, want[k], 32'(want[k] >> 2));
            end
        end
    endtask

    task automatic test_misalign();
        fill_linear();
        do_reset();
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 10'h102, 1'b1);
`ifdef RV_FETCH_MISALIGN_EN
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1);
            n_checks++;
            if (misalign_o !== 1'b1 || if_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL misalign_hold[%0d]: mis=%b valid=%b, want 1/0", k, misalign_o, if_valid_o);
            end
        end
        cyc(1'b1, 10'h200, 1'b1);
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (misalign_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== 10'h200 || if_instr_o !== 32'd128) begin
            n_fail++;
            $display("FAIL misalign_clear: mis=%b valid=%b pc=%h instr=%h, want 0/1/200/80",
                     misalign_o, if_valid_o, if_pc_o, if_instr_o);
        end
`else
        cyc(1'b0, '0, 1'b1);
        n_checks++;
        if (misalign_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== 10'h100 || if_instr_o !== 32'd64) begin
            n_fail++;
            $display("FAIL misalign_ignored: mis=%b valid=%b pc=%h instr=%h, want 0/1/100/40",
                     misalign_o, if_valid_o, if_pc_o, if_instr_o);
        end
`endif
    endtask

    // Random traffic against a stream model: the presented instruction is
    // always the next one in program order; it advances only on transfer and
    // jumps on redirect. Every non-redirect cycle after reset must be valid.
    task automatic test_random();
        logic [PW-1:0] exp_pc;
        logic          rd, rdy;
        logic [PW-1:0] tgt;
        int            errs;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        do_reset();
        exp_pc = 10'h000;
        errs = 0;
        for (int k = 0; k < 400; k++) begin
            rd  = ($urandom_range(0, 7) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            tgt = 10'($urandom_range(0, 255) * 4);
            cyc(rd, tgt, rdy);
            n_checks++;
            if (if_valid_o !== !rd || misalign_o !== 1'b0 ||
                (!rd && (if_pc_o !== exp_pc || if_instr_o !== mem[exp_pc[PW-1:2]]))) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random[%0d]: valid=%b pc=%h instr=%h mis=%b, want %b/%h/%h/0",
                             k, if_valid_o, if_pc_o, if_instr_o, misalign_o, !rd, exp_pc,
                             mem[exp_pc[PW-1:2]]);
                errs++;
            end
            if (rd) exp_pc = tgt;
            else if (rdy) exp_pc = exp_pc + 10'd4;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_misalign();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
